// File: rtl/axil_shared_ram_arbiter_if.sv
// AXI-Lite bundle used on both sides of the shared-RAM arbiter.
// Master drives requests; slave answers. Read-only users leave the write channels idle.
interface axil_shared_ram_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) ();
  logic [ADDR_WIDTH-1:0]   araddr;
  logic                    arvalid;
  logic                    arready;
  logic [DATA_WIDTH-1:0]   rdata;
  logic                    rvalid;
  logic                    rready;
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic                    awvalid;
  logic                    awready;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wvalid;
  logic                    wready;
  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;

  modport master (
    output araddr, arvalid, input arready,
    input  rdata, rvalid, output rready,
    output awaddr, awvalid, input awready,
    output wdata, wstrb, wvalid, input wready,
    input  bresp, bvalid, output bready
  );

  modport slave (
    input  araddr, arvalid, output arready,
    output rdata, rvalid, input rready,
    input  awaddr, awvalid, output awready,
    input  wdata, wstrb, wvalid, output wready,
    output bresp, bvalid, input bready
  );
endinterface

// File: rtl/axil_shared_ram_arbiter.sv
// Shares one AXI-Lite RAM between the CPU instruction (read-only) and data ports, one transaction at a time.
// Define AXIL_ARB_ROUND_ROBIN_EN to alternate priority between instruction and data requesters.
//
// state   | meaning
// IDLE    | no owner; arbitrate among pending requests
// RD_ADDR | AR channel of the granted reader forwarded to the RAM
// RD_DATA | R channel routed back to the granted reader
// WR_XFER | data-port AW and W forwarded independently until both handshake
// WR_RESP | B channel routed back to the data port
module axil_shared_ram_arbiter #(
  parameter int          ADDR_WIDTH   = 32,
  parameter int          DATA_WIDTH   = 32,
  parameter int          M_ADDR_WIDTH = 17,
  parameter logic [31:0] INSTR_BASE   = 32'h0000_0000,
  parameter logic [31:0] DATA_BASE    = 32'h8000_0000,
  parameter logic [31:0] INSTR_OFFSET = 32'h0000_0000,
  parameter logic [31:0] DATA_OFFSET  = 32'h0001_0000
) (
  input  logic                        i_Clock,
  input  logic                        i_Reset,
  axil_shared_ram_arbiter_if.slave    s_instruction_memory_axil,
  axil_shared_ram_arbiter_if.slave    s_data_memory_axil,
  axil_shared_ram_arbiter_if.master   m_axil,
  output logic [1:0]                  o_Grant
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_ADDR = 3'd1,
    RD_DATA = 3'd2,
    WR_XFER = 3'd3,
    WR_RESP = 3'd4
  } state_t;

  localparam logic [1:0] GNT_NONE  = 2'b00;
  localparam logic [1:0] GNT_INSTR = 2'b01;
  localparam logic [1:0] GNT_DRD   = 2'b10;
  localparam logic [1:0] GNT_DWR   = 2'b11;

  state_t                state;
  logic                  aw_done;
  logic                  w_done;
  logic [1:0]            pick;
  logic                  req_i;
  logic                  req_dr;
  logic                  req_dw;
  logic                  aw_hs;
  logic                  w_hs;
  logic [ADDR_WIDTH-1:0] instr_ar_rb;
  logic [ADDR_WIDTH-1:0] data_ar_rb;
  logic [ADDR_WIDTH-1:0] data_aw_rb;
  logic                  unused_ok;

`ifdef AXIL_ARB_ROUND_ROBIN_EN
  logic                  last_data;
`endif

  assign req_i  = s_instruction_memory_axil.arvalid;
  assign req_dr = s_data_memory_axil.arvalid;
  assign req_dw = s_data_memory_axil.awvalid | s_data_memory_axil.wvalid;

  // Rebase into the RAM window; arithmetic wraps modulo 2^ADDR_WIDTH before truncation.
  assign instr_ar_rb = s_instruction_memory_axil.araddr - ADDR_WIDTH'(INSTR_BASE) + ADDR_WIDTH'(INSTR_OFFSET);
  assign data_ar_rb  = s_data_memory_axil.araddr - ADDR_WIDTH'(DATA_BASE) + ADDR_WIDTH'(DATA_OFFSET);
  assign data_aw_rb  = s_data_memory_axil.awaddr - ADDR_WIDTH'(DATA_BASE) + ADDR_WIDTH'(DATA_OFFSET);

  assign aw_hs = m_axil.awvalid & m_axil.awready;
  assign w_hs  = m_axil.wvalid & m_axil.wready;

  always_comb begin
    pick = GNT_NONE;
    if (req_dw)
      pick = GNT_DWR;
    else if (req_dr)
      pick = GNT_DRD;
    else if (req_i)
      pick = GNT_INSTR;
`ifdef AXIL_ARB_ROUND_ROBIN_EN
    if (req_i && last_data)
      pick = GNT_INSTR;
`endif
  end

  always_comb begin
    m_axil.araddr  = '0;
    m_axil.arvalid = 1'b0;
    m_axil.rready  = 1'b0;
    m_axil.awaddr  = '0;
    m_axil.awvalid = 1'b0;
    m_axil.wdata   = '0;
    m_axil.wstrb   = '0;
    m_axil.wvalid  = 1'b0;
    m_axil.bready  = 1'b0;

    s_instruction_memory_axil.arready = 1'b0;
    s_instruction_memory_axil.rdata   = '0;
    s_instruction_memory_axil.rvalid  = 1'b0;
    s_instruction_memory_axil.awready = 1'b0;
    s_instruction_memory_axil.wready  = 1'b0;
    s_instruction_memory_axil.bresp   = 2'b00;
    s_instruction_memory_axil.bvalid  = 1'b0;

    s_data_memory_axil.arready = 1'b0;
    s_data_memory_axil.rdata   = '0;
    s_data_memory_axil.rvalid  = 1'b0;
    s_data_memory_axil.awready = 1'b0;
    s_data_memory_axil.wready  = 1'b0;
    s_data_memory_axil.bresp   = 2'b00;
    s_data_memory_axil.bvalid  = 1'b0;

    case (state)
      RD_ADDR: begin
        if (o_Grant == GNT_INSTR) begin
          m_axil.arvalid = s_instruction_memory_axil.arvalid;
          m_axil.araddr  = instr_ar_rb[M_ADDR_WIDTH-1:0];
          s_instruction_memory_axil.arready = m_axil.arready;
        end else begin
          m_axil.arvalid = s_data_memory_axil.arvalid;
          m_axil.araddr  = data_ar_rb[M_ADDR_WIDTH-1:0];
          s_data_memory_axil.arready = m_axil.arready;
        end
      end
      RD_DATA: begin
        if (o_Grant == GNT_INSTR) begin
          m_axil.rready = s_instruction_memory_axil.rready;
          s_instruction_memory_axil.rvalid = m_axil.rvalid;
          s_instruction_memory_axil.rdata  = m_axil.rdata;
        end else begin
          m_axil.rready = s_data_memory_axil.rready;
          s_data_memory_axil.rvalid = m_axil.rvalid;
          s_data_memory_axil.rdata  = m_axil.rdata;
        end
      end
      WR_XFER: begin
        // A channel that already handshook is masked so it cannot issue twice.
        m_axil.awvalid = s_data_memory_axil.awvalid & ~aw_done;
        m_axil.awaddr  = data_aw_rb[M_ADDR_WIDTH-1:0];
        s_data_memory_axil.awready = m_axil.awready & ~aw_done;
        m_axil.wvalid  = s_data_memory_axil.wvalid & ~w_done;
        m_axil.wdata   = s_data_memory_axil.wdata;
        m_axil.wstrb   = s_data_memory_axil.wstrb;
        s_data_memory_axil.wready = m_axil.wready & ~w_done;
      end
      WR_RESP: begin
        m_axil.bready = s_data_memory_axil.bready;
        s_data_memory_axil.bvalid = m_axil.bvalid;
        s_data_memory_axil.bresp  = m_axil.bresp;
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_Clock or negedge i_Reset) begin
    if (!i_Reset) begin
      state   <= IDLE;
      o_Grant <= GNT_NONE;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
`ifdef AXIL_ARB_ROUND_ROBIN_EN
      last_data <= 1'b1;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (pick != GNT_NONE) begin
            o_Grant <= pick;
            state   <= (pick == GNT_DWR) ? WR_XFER : RD_ADDR;
`ifdef AXIL_ARB_ROUND_ROBIN_EN
            last_data <= pick[1];
`endif
          end
        end
        RD_ADDR: begin
          if (m_axil.arvalid && m_axil.arready)
            state <= RD_DATA;
        end
        RD_DATA: begin
          if (m_axil.rvalid && m_axil.rready) begin
            state   <= IDLE;
            o_Grant <= GNT_NONE;
          end
        end
        WR_XFER: begin
          if (aw_hs)
            aw_done <= 1'b1;
          if (w_hs)
            w_done <= 1'b1;
          if ((aw_done || aw_hs) && (w_done || w_hs))
            state <= WR_RESP;
        end
        WR_RESP: begin
          if (m_axil.bvalid && m_axil.bready) begin
            aw_done <= 1'b0;
            w_done  <= 1'b0;
            state   <= IDLE;
            o_Grant <= GNT_NONE;
          end
        end
        default: begin
          state   <= IDLE;
          o_Grant <= GNT_NONE;
        end
      endcase
    end
  end

  // Instruction write channels and truncated upper address bits are intentionally dropped.
  assign unused_ok = ^{s_instruction_memory_axil.awaddr, s_instruction_memory_axil.awvalid,
                       s_instruction_memory_axil.wdata, s_instruction_memory_axil.wstrb,
                       s_instruction_memory_axil.wvalid, s_instruction_memory_axil.bready,
                       instr_ar_rb[ADDR_WIDTH-1:M_ADDR_WIDTH], data_ar_rb[ADDR_WIDTH-1:M_ADDR_WIDTH],
                       data_aw_rb[ADDR_WIDTH-1:M_ADDR_WIDTH]};

endmodule
